conv_encoder_mapper: RTL and testbench

- Transmit-side counterpart of the Fano sequence decoder channel.
- Takes an information bit stream and applies optional differential precoding.
- Encodes the bits with a rate-1/2 convolutional mother code, then punctures to the selected code rate.
- Maps coded bit pairs onto signed 10-bit QPSK I/Q samples in the same format the decoder consumes. Used as the loopback/test-signal source in front of each decoder channel.

---
 rtl/conv_encoder_mapper.sv | 169 ++++++++++++++++
 tb/tb_conv_encoder_mapper.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_mapper.sv
// conv_encoder_mapper: differential precoder + K-stage rate-1/2 convolutional encoder,
// puncturing to 1/2, 2/3, 3/4 or 7/8, and mapping of coded bit pairs onto QPSK I/Q samples.
// Ports: clk/reset_n (sync, active-low); i_code_rate/i_diff_en config; i_vld/i_bit/o_rdy bit input;
//        o_vld/o_data_I/o_data_Q/i_rdy symbol output (bit 0 -> +AMP, bit 1 -> -AMP, first bit on I).
// Latency: a bit that completes a pair at edge t gives o_vld after edge t+1.
// Backpressure: a 4-bit queue sits between encoder and output register; o_rdy is high while <= 2 bits are queued.
module conv_encoder_mapper #(
  parameter int                K        = 7,
  parameter logic [K-1:0]      G0       = 7'o171,
  parameter logic [K-1:0]      G1       = 7'o133,
  parameter int                IQ_WIDTH = 10,
  parameter int                AMP      = 200
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          i_code_rate,
  input  logic                i_diff_en,
  input  logic                i_vld,
  input  logic                i_bit,
  output logic                o_rdy,
  output logic                o_vld,
  output logic [IQ_WIDTH-1:0] o_data_I,
  output logic [IQ_WIDTH-1:0] o_data_Q,
  input  logic                i_rdy
);

  localparam logic [IQ_WIDTH-1:0] POS = IQ_WIDTH'(AMP);
  localparam logic [IQ_WIDTH-1:0] NEG = IQ_WIDTH'(-AMP);

  // Keep pattern {keep_x, keep_y} for a given rate and puncture phase.
  function automatic logic [1:0] keep_f(input logic [1:0] r, input logic [2:0] p);
    logic [1:0] k;
    k = 2'b11;
    case (r)
      2'd1: k = (p == 3'd0) ? 2'b11 : 2'b01;
      2'd2: case (p)
              3'd0:    k = 2'b11;
              3'd1:    k = 2'b01;
              default: k = 2'b10;
            endcase
      2'd3: case (p)
              3'd0:             k = 2'b11;
              3'd4, 3'd6:       k = 2'b10;
              default:          k = 2'b01;
            endcase
      default: k = 2'b11;
    endcase
    return k;
  endfunction

  function automatic logic [2:0] last_phase_f(input logic [1:0] r);
    case (r)
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      2'd3:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  logic [1:0]          rate_q, rate_d;
  logic                diff_q, diff_d;
  logic                prev_q, prev_d;   // last precoded bit d[n-1]
  logic [K-2:0]        sr_q, sr_d;       // d[n-1] at MSB .. d[n-K+1] at LSB
  logic [2:0]          ph_q, ph_d;
  logic [3:0]          qb_q, qb_d;       // bit queue, oldest bit at index 0
  logic [2:0]          cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic                vld_q, vld_d;
  logic [IQ_WIDTH-1:0] i_q, i_d, q_q, q_d;

  logic         accept, d_bit, enc_x, enc_y, pop, idle, cfg_chg;
  logic [1:0]   keep;
  logic [K-1:0] win;

  assign accept  = i_vld & rdy_q;
  assign d_bit   = diff_q ? (i_bit ^ prev_q) : i_bit;
  assign win     = {d_bit, sr_q};
  assign enc_x   = ^(win & G0);
  assign enc_y   = ^(win & G1);
  assign keep    = keep_f(rate_q, ph_q);
  // Pop uses the count before this edge's pushes, so a freshly pushed pair waits one edge.
  assign pop     = (cnt_q >= 3'd2) && (!vld_q || i_rdy);
  assign idle    = !i_vld && (cnt_q == 3'd0) && !vld_q;
  assign cfg_chg = idle && ((i_code_rate != rate_q) || (i_diff_en != diff_q));

  always_comb begin
    qb_d   = qb_q;
    cnt_d  = cnt_q;
    rate_d = rate_q;
    diff_d = diff_q;
    prev_d = prev_q;
    sr_d   = sr_q;
    ph_d   = ph_q;
    vld_d  = vld_q;
    i_d    = i_q;
    q_d    = q_q;

    if (pop) begin
      qb_d  = {2'b00, qb_q[3:2]};
      cnt_d = cnt_q - 3'd2;
      vld_d = 1'b1;
      i_d   = qb_q[0] ? NEG : POS;
      q_d   = qb_q[1] ? NEG : POS;
    end else if (i_rdy) begin
      vld_d = 1'b0;
    end

    if (accept) begin
      // cnt_q <= 2 whenever a bit is accepted, so both writes land within the 4-bit queue.
      if (keep[1]) begin
        qb_d[cnt_d[1:0]] = enc_x;
        cnt_d            = cnt_d + 3'd1;
      end
      if (keep[0]) begin
        qb_d[cnt_d[1:0]] = enc_y;
        cnt_d            = cnt_d + 3'd1;
      end
      prev_d = d_bit;
      sr_d   = {d_bit, sr_q[K-2:1]};
      ph_d   = (ph_q == last_phase_f(rate_q)) ? 3'd0 : ph_q + 3'd1;
    end

    // Config is only sampled while idle; the encoder window deliberately survives a change.
    if (idle) begin
      rate_d = i_code_rate;
      diff_d = i_diff_en;
    end
    if (cfg_chg) begin
      prev_d = 1'b0;
      ph_d   = 3'd0;
    end

    rdy_d = (cnt_d <= 3'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate_q <= i_code_rate;
      diff_q <= i_diff_en;
      prev_q <= 1'b0;
      sr_q   <= '0;
      ph_q   <= 3'd0;
      qb_q   <= 4'd0;
      cnt_q  <= 3'd0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      i_q    <= '0;
      q_q    <= '0;
    end else begin
      rate_q <= rate_d;
      diff_q <= diff_d;
      prev_q <= prev_d;
      sr_q   <= sr_d;
      ph_q   <= ph_d;
      qb_q   <= qb_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      vld_q  <= vld_d;
      i_q    <= i_d;
      q_q    <= q_d;
    end
  end

  assign o_rdy    = rdy_q;
  assign o_vld    = vld_q;
  assign o_data_I = i_q;
  assign o_data_Q = q_q;

endmodule

// File: tb/tb_conv_encoder_mapper.sv
// Testbench for conv_encoder_mapper: directed and random scenarios against a queue-based reference model.
module tb_conv_encoder_mapper;
  localparam int         K   = 7;
  localparam logic [6:0] G0  = 7'o171;
  localparam logic [6:0] G1  = 7'o133;
  localparam int         AMP = 200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] i_code_rate = 2'd0;
  logic       i_diff_en = 1'b0;
  logic       i_vld = 1'b0;
  logic       i_bit = 1'b0;
  logic       i_rdy = 1'b0;
  logic       o_rdy, o_vld;
  logic [9:0] o_data_I, o_data_Q;

  always #5 clk = ~clk;

  conv_encoder_mapper dut (
    .clk(clk), .reset_n(reset_n), .i_code_rate(i_code_rate), .i_diff_en(i_diff_en),
    .i_vld(i_vld), .i_bit(i_bit), .o_rdy(o_rdy), .o_vld(o_vld),
    .o_data_I(o_data_I), .o_data_Q(o_data_Q), .i_rdy(i_rdy)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Reference model state
  bit         mq[$];
  bit         mvld, mrdy;
  logic [9:0] mI, mQ;
  int         mrate;
  bit         mdiff, dprev;
  bit         dh[16];
  int         phase;
  int         nsym;
  logic [19:0] sym_log[$];
  bit         in_bits[$];
  bit         acc_last;

  function automatic logic [9:0] amp_of(bit b);
    return b ? 10'(-AMP) : 10'(AMP);
  endfunction

  task automatic model_reset();
    mq.delete();
    mvld = 0; mrdy = 0; mI = '0; mQ = '0;
    mrate = int'(i_code_rate); mdiff = i_diff_en;
    dprev = 0; phase = 0;
    foreach (dh[i]) dh[i] = 0;
  endtask

  task automatic model_encode(bit u);
    bit d, x, y;
    string px, py;
    byte cx, cy;
    case (mrate)
      0: begin px = "1";       py = "1";       end
      1: begin px = "10";      py = "11";      end
      2: begin px = "101";     py = "110";     end
      default: begin px = "1000101"; py = "1111010"; end
    endcase
    d = mdiff ? (u ^ dprev) : u;
    dprev = d;
    for (int i = 15; i > 0; i--) dh[i] = dh[i-1];
    dh[0] = d;
    x = 0; y = 0;
    for (int i = 0; i < K; i++) begin
      x = x ^ (G0[K-1-i] & dh[i]);
      y = y ^ (G1[K-1-i] & dh[i]);
    end
    cx = px[phase];
    cy = py[phase];
    if (cx == 8'h31) mq.push_back(x);
    if (cy == 8'h31) mq.push_back(y);
    phase = (phase + 1) % px.len();
  endtask

  // One clock: compare outputs to the model, then apply this edge to the model.
  task automatic tick();
    bit acc, pop, idle;
    @(negedge clk);
    if (chk_en) begin
      checks++;
      if (o_vld !== mvld) begin
        failures++;
        $display("FAIL o_vld: got %b expected %b at %0t", o_vld, mvld, $time);
      end
      checks++;
      if (o_rdy !== mrdy) begin
        failures++;
        $display("FAIL o_rdy: got %b expected %b at %0t", o_rdy, mrdy, $time);
      end
      if (mvld) begin
        checks++;
        if (o_data_I !== mI || o_data_Q !== mQ) begin
          failures++;
          $display("FAIL iq_data: got I=%h Q=%h expected I=%h Q=%h at %0t", o_data_I, o_data_Q, mI, mQ, $time);
        end
      end
      checks++;
      if (dut.cnt_q > 3'd4) begin
        failures++;
        $display("FAIL queue_bound: got count %0d expected <= 4", dut.cnt_q);
      end
    end
    acc = i_vld && mrdy;
    if (!reset_n) begin
      model_reset();
      acc = 0;
    end else begin
      if (mvld && i_rdy) begin
        nsym++;
        sym_log.push_back({o_data_I, o_data_Q});
      end
      pop  = (mq.size() >= 2) && (!mvld || i_rdy);
      idle = !i_vld && (mq.size() == 0) && !mvld;
      if (pop) begin
        mI = amp_of(mq[0]);
        mQ = amp_of(mq[1]);
        void'(mq.pop_front());
        void'(mq.pop_front());
        mvld = 1;
      end else if (i_rdy) begin
        mvld = 0;
      end
      if (acc) model_encode(i_bit);
      if (idle && (int'(i_code_rate) != mrate || i_diff_en != mdiff)) begin
        mrate = int'(i_code_rate);
        mdiff = i_diff_en;
        dprev = 0;
        phase = 0;
      end
      mrdy = (mq.size() <= 2);
    end
    acc_last = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(int vld_pct, int rdy_pct, int budget);
    int cyc = 0;
    while ((in_bits.size() > 0 || mq.size() >= 2 || mvld) && cyc < budget) begin
      i_vld = (in_bits.size() > 0) && ($urandom_range(99) < vld_pct);
      i_bit = (in_bits.size() > 0) ? in_bits[0] : 1'b0;
      i_rdy = ($urandom_range(99) < rdy_pct);
      tick();
      if (acc_last) void'(in_bits.pop_front());
      cyc++;
    end
    i_vld = 0;
    checks++;
    if (cyc >= budget) begin
      failures++;
      $display("FAIL drive_timeout: got %0d cycles expected < %0d", cyc, budget);
      in_bits.delete();
    end
  endtask

  task automatic do_reset(logic [1:0] rate, logic diff);
    i_vld = 0;
    i_code_rate = rate;
    i_diff_en = diff;
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    sym_log.delete();
    nsym = 0;
  endtask

  task automatic check_sym(string name, int idx, logic [9:0] ei, logic [9:0] eq);
    checks++;
    if (idx >= sym_log.size()) begin
      failures++;
      $display("FAIL %s: got %0d symbols expected index %0d present", name, sym_log.size(), idx);
    end else if (sym_log[idx] !== {ei, eq}) begin
      failures++;
      $display("FAIL %s: got I=%h Q=%h expected I=%h Q=%h", name, sym_log[idx][19:10], sym_log[idx][9:0], ei, eq);
    end
  endtask

  task automatic test_reset();
    i_code_rate = 0; i_diff_en = 0; reset_n = 0; i_rdy = 1;
    chk_en = 0;
    tick();
    chk_en = 1;
    tick();
    checks++;
    if (o_vld !== 1'b0 || o_rdy !== 1'b0 || o_data_I !== 10'd0 || o_data_Q !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: got vld=%b rdy=%b I=%h Q=%h expected 0 0 000 000", o_vld, o_rdy, o_data_I, o_data_Q);
    end
    reset_n = 1;
    tick();
    checks++;
    if (o_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rdy_after_reset: got %b expected 1", o_rdy);
    end
  endtask

  task automatic test_rate12();
    do_reset(2'd0, 1'b0);
    in_bits = '{1, 0};
    drive_bits(100, 100, 50);
    check_sym("rate12_sym0", 0, 10'h338, 10'h338);
    check_sym("rate12_sym1", 1, 10'h338, 10'h0C8);
  endtask

  task automatic test_rate23();
    do_reset(2'd1, 1'b0);
    in_bits = '{1, 0};
    drive_bits(100, 100, 50);
    checks++;
    if (sym_log.size() != 1) begin
      failures++;
      $display("FAIL rate23_count: got %0d symbols expected 1", sym_log.size());
    end
    check_sym("rate23_sym0", 0, 10'h338, 10'h338);
    in_bits = '{1};
    drive_bits(100, 100, 50);
    check_sym("rate23_sym1", 1, 10'h0C8, 10'h0C8);
  endtask

  task automatic test_rate34_random();
    do_reset(2'd2, 1'b0);
    for (int i = 0; i < 300; i++) in_bits.push_back(1'($urandom_range(1)));
    drive_bits(100, 100, 2000);
    checks++;
    if (nsym != 200) begin
      failures++;
      $display("FAIL rate34_count: got %0d symbols expected 200", nsym);
    end
  endtask

  task automatic test_diff();
    logic [19:0] log_a[$];
    do_reset(2'd0, 1'b1);
    in_bits = '{1, 1, 1};
    drive_bits(100, 100, 50);
    log_a = sym_log;
    check_sym("diff_sym0", 0, 10'h338, 10'h338);
    do_reset(2'd0, 1'b0);
    in_bits = '{1, 0, 1};
    drive_bits(100, 100, 50);
    checks++;
    if (log_a.size() != 3 || sym_log.size() != 3 || log_a != sym_log) begin
      failures++;
      $display("FAIL diff_equiv: got %0d/%0d symbols, streams differ or short, expected 3 identical", log_a.size(), sym_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset(2'd0, 1'b0);
    for (int i = 0; i < 200; i++) in_bits.push_back(1'($urandom_range(1)));
    drive_bits(70, 50, 5000);
    checks++;
    if (nsym != 200) begin
      failures++;
      $display("FAIL bp12_count: got %0d symbols expected 200", nsym);
    end
    // Idle config change to 7/8 with precoding, no reset in between.
    i_code_rate = 2'd3;
    i_diff_en = 1'b1;
    i_rdy = 1;
    repeat (3) tick();
    nsym = 0;
    for (int i = 0; i < 140; i++) in_bits.push_back(1'($urandom_range(1)));
    drive_bits(80, 50, 5000);
    checks++;
    if (nsym != 80) begin
      failures++;
      $display("FAIL bp78_count: got %0d symbols expected 80", nsym);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2'd0, 1'b0);
    i_rdy = 0; i_vld = 1; i_bit = 1;
    repeat (3) tick();
    i_vld = 0;
    checks++;
    if (o_vld !== 1'b1) begin
      failures++;
      $display("FAIL mid_pending: got o_vld=%b expected 1", o_vld);
    end
    reset_n = 0;
    tick();
    checks++;
    if (o_vld !== 1'b0 || o_data_I !== 10'd0 || o_data_Q !== 10'd0) begin
      failures++;
      $display("FAIL mid_reset: got vld=%b I=%h Q=%h expected 0 000 000", o_vld, o_data_I, o_data_Q);
    end
    reset_n = 1;
    tick();
    sym_log.delete();
    in_bits = '{1};
    drive_bits(100, 100, 50);
    check_sym("mid_restart", 0, 10'h338, 10'h338);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rate12();
    test_rate23();
    test_rate34_random();
    test_diff();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
